regbank_rd_port: RTL

//   Parametrised register bank: NUM_REGS x DATA_W storage, one write port, NUM_RD registered read ports.

---
 rtl/regbank_pkg.sv | 23 ++
 rtl/regbank_mux_n.sv | 23 ++
 rtl/regbank_rd_port.sv | 82 ++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared constants, clog2 helper and read-port bundle type for the register bank
package regbank_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    // Read-port result bundle at the default register width
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DEF_DATA_W-1:0] data;
    } rd_port_t;

endpackage

// File: rtl/regbank_mux_n.sv
// regbank_mux_n: combinational N:1 register select with in-range flag
module regbank_mux_n
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    localparam int AW      = clog2(NUM_REGS)
) (
    input  logic [NUM_REGS*DATA_W-1:0] regs,
    input  logic [AW-1:0]              sel,
    output logic [DATA_W-1:0]          data,
    output logic                       in_range
);

    // Select the addressed register; an index past the last register yields zero
    always_comb begin
        data     = '0;
        in_range = 32'(sel) < NUM_REGS;
        for (int i = 0; i < NUM_REGS; i++)
            if (32'(sel) == i) data = regs[i*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/regbank_rd_port.sv
// regbank_rd_port: NUM_REGS x DATA_W register bank, one write port, NUM_RD registered read ports (REGBANK_BYPASS_EN enables write-to-read forwarding)
module regbank_rd_port
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = 0,
    localparam int AW      = clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_err
);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } port_t;

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic                            wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < NUM_REGS) && !(ZERO_R0 != 0 && wr_addr == '0);

    // Register storage: accept only in-range, writable indices
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem <= '0;
        else if (wr_ok) mem[wr_addr] <= wr_data;
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] sel_data;
        logic [DATA_W-1:0] val;
        logic              in_range;
        logic              fwd;
        port_t             q;

        assign addr = rd_addr[g*AW +: AW];

        regbank_mux_n #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux (
            .regs     (mem),
            .sel      (addr),
            .data     (sel_data),
            .in_range (in_range)
        );

`ifdef REGBANK_BYPASS_EN
        assign fwd = wr_ok && wr_addr == addr;
`else
        assign fwd = 1'b0;
`endif

        assign val = (!in_range || (ZERO_R0 != 0 && addr == '0)) ? '0 : fwd ? wr_data : sel_data;

        // Output register: valid pulses one cycle per request, data/err hold between requests
        always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= '0;
            else begin
                q.valid <= rd_req[g];
                if (rd_req[g]) begin
                    q.data <= val;
                    q.err  <= !in_range;
                end
            end
        end

        assign rd_valid[g]                  = q.valid;
        assign rd_err[g]                    = q.err;
        assign rd_data[g*DATA_W +: DATA_W]  = q.data;
    end

endmodule
